// File: rtl/img_pkg.sv
// Shared framing definitions for the memory-image transmitter and receiver.
// Both ends import this so header bytes and per-word byte counts stay identical.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif

package img_pkg;

    localparam int IMG_ADDR_W = `ADDR_WIDTH;

    localparam logic [7:0] IMG_HDR0 = 8'h55;
    localparam logic [7:0] IMG_HDR1 = 8'hAA;

    localparam logic [1:0] IMG_META_BYTES = 2'd2;
    localparam logic [1:0] IMG_PMEM_BYTES = 2'd3;
    localparam logic [1:0] IMG_DMEM_BYTES = 2'd2;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        META,
        P_ADDR,
        P_DATA,
        P_SEND,
        D_ADDR,
        D_DATA,
        D_SEND,
        FIN
    } img_send_state_t;

    // Metadata sizes travel as zero-extended 16-bit values.
    function automatic logic [17:0] imgSizeWord(input logic [IMG_ADDR_W-1:0] size);
        logic [17:0] w;
        w = '0;
        w[IMG_ADDR_W-1:0] = size;
        return w;
    endfunction

endpackage

// File: rtl/img_send_word_ser.sv
// Word-to-byte serializer: emits 2 or 3 MSB-first bytes of a loaded word,
// never on back-to-back cycles so the UART's one-cycle ready dip is covered.
module img_word_ser
    import img_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [17:0] i_word,
    input  logic [1:0]  i_nBytes,
    input  logic        i_txReady,
    output logic [7:0]  o_byte,
    output logic        o_wr,
    output logic        o_last
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;
    logic        r_wrPrev;
    logic        w_issue;

    // The strobe must follow tx_ready in the same cycle, so it is decoded from state
    assign w_issue = (r_cnt != 2'd0) && i_txReady && !r_wrPrev;
    assign o_wr    = w_issue;
    assign o_last  = w_issue && (r_cnt == 2'd1);
    assign o_byte  = r_shift[23:16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_cnt    <= 2'd0;
            r_wrPrev <= 1'b0;
        end else begin
            r_wrPrev <= w_issue;
            if (i_load) begin
                r_cnt   <= i_nBytes;
                r_shift <= (i_nBytes == IMG_PMEM_BYTES) ? {6'd0, i_word}
                                                        : {i_word[15:0], 8'd0};
            end else if (w_issue) begin
                r_cnt   <= r_cnt - 2'd1;
                r_shift <= {r_shift[15:0], 8'd0};
            end
        end
    end

endmodule

// File: rtl/img_send.sv
// Streams header, size metadata, program memory and data memory as a byte
// image to the UART transmitter in the format the MCU image receiver expects.
module img_send
    import img_pkg::*;
#(
    parameter logic [7:0] HDR0 = IMG_HDR0,
    parameter logic [7:0] HDR1 = IMG_HDR1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [IMG_ADDR_W-1:0] i_pmemSize,
    input  logic [IMG_ADDR_W-1:0] i_dmemSize,
    output logic [IMG_ADDR_W-1:0] o_pmemAddr,
    input  logic [17:0]           i_pmemRdData,
    output logic [IMG_ADDR_W-1:0] o_dmemAddr,
    output logic                  o_dmemRd,
    input  logic [15:0]           i_dmemRdData,
    output logic [7:0]            o_txData,
    output logic                  o_txWr,
    input  logic                  i_txReady,
    output logic                  o_busy,
    output logic                  o_done
);

    img_send_state_t       r_state;
    logic [IMG_ADDR_W-1:0] r_pmemSize;
    logic [IMG_ADDR_W-1:0] r_dmemSize;
    logic [IMG_ADDR_W-1:0] r_widx;
    logic [1:0]            r_bidx;
    logic [IMG_ADDR_W-1:0] r_pmemAddr;
    logic [IMG_ADDR_W-1:0] r_dmemAddr;
    logic                  r_dmemRd;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_load;
    logic [17:0]           w_word;
    logic [1:0]            w_nBytes;
    logic                  w_last;
    logic [IMG_ADDR_W-1:0] w_widxNext;

    assign w_widxNext = r_widx + IMG_ADDR_W'(1);

    // The next word is handed over on the same edge the previous one finishes
    always_comb begin
        w_load   = 1'b0;
        w_word   = '0;
        w_nBytes = IMG_META_BYTES;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    w_word = {2'b00, HDR0, HDR1};
                end
            end
            HDR: begin
                if (w_last) begin
                    w_load = 1'b1;
                    w_word = imgSizeWord(r_pmemSize);
                end
            end
            META: begin
                if (w_last && (r_bidx == 2'd0)) begin
                    w_load = 1'b1;
                    w_word = imgSizeWord(r_dmemSize);
                end
            end
            P_DATA: begin
                w_load   = 1'b1;
                w_word   = i_pmemRdData;
                w_nBytes = IMG_PMEM_BYTES;
            end
            D_DATA: begin
                w_load   = 1'b1;
                w_word   = {2'b00, i_dmemRdData};
                w_nBytes = IMG_DMEM_BYTES;
            end
            default: ;
        endcase
    end

    img_word_ser u_ser (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_word   (w_word),
        .i_nBytes (w_nBytes),
        .i_txReady(i_txReady),
        .o_byte   (o_txData),
        .o_wr     (o_txWr),
        .o_last   (w_last)
    );

    // Terminal tests run before widx increments, so a maximum size never wraps it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pmemSize <= '0;
            r_dmemSize <= '0;
            r_widx     <= '0;
            r_bidx     <= 2'd0;
            r_pmemAddr <= '0;
            r_dmemAddr <= '0;
            r_dmemRd   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_dmemRd <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_pmemSize <= i_pmemSize;
                        r_dmemSize <= i_dmemSize;
                        r_widx     <= '0;
                        r_bidx     <= 2'd0;
                        r_busy     <= 1'b1;
                        r_state    <= HDR;
                    end
                end
                HDR: begin
                    if (w_last) r_state <= META;
                end
                META: begin
                    if (w_last) begin
                        if (r_bidx == 2'd0) begin
                            r_bidx <= 2'd1;
                        end else if (r_pmemSize != '0) begin
                            r_pmemAddr <= r_widx;
                            r_state    <= P_ADDR;
                        end else if (r_dmemSize != '0) begin
                            r_dmemAddr <= r_widx;
                            r_dmemRd   <= 1'b1;
                            r_state    <= D_ADDR;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end
                    end
                end
                P_ADDR: r_state <= P_DATA;
                P_DATA: r_state <= P_SEND;
                P_SEND: begin
                    if (w_last) begin
                        if (w_widxNext < r_pmemSize) begin
                            r_widx     <= w_widxNext;
                            r_pmemAddr <= w_widxNext;
                            r_state    <= P_ADDR;
                        end else begin
                            r_widx <= '0;
                            if (r_dmemSize != '0) begin
                                r_dmemAddr <= '0;
                                r_dmemRd   <= 1'b1;
                                r_state    <= D_ADDR;
                            end else begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= FIN;
                            end
                        end
                    end
                end
                D_ADDR: r_state <= D_DATA;
                D_DATA: r_state <= D_SEND;
                D_SEND: begin
                    if (w_last) begin
                        if (w_widxNext < r_dmemSize) begin
                            r_widx     <= w_widxNext;
                            r_dmemAddr <= w_widxNext;
                            r_dmemRd   <= 1'b1;
                            r_state    <= D_ADDR;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end
                    end
                end
                FIN:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_pmemAddr = r_pmemAddr;
    assign o_dmemAddr = r_dmemAddr;
    assign o_dmemRd   = r_dmemRd;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_img_send.sv
// Self-checking bench for img_send: compares the emitted byte stream with an
// image built directly from the framing rules and watches the UART handshake.
module tb_img_send;
    import img_pkg::*;

    localparam int AW = IMG_ADDR_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] pmemSize, dmemSize, pmemAddr, dmemAddr;
    logic [17:0]   pmemRdData;
    logic          dmemRd;
    logic [15:0]   dmemRdData;
    logic [7:0]    txData;
    logic          txWr, txReady, busy, done;

    logic [17:0] pmem [0:63];
    logic [15:0] dmem [0:63];
    logic [7:0]  expQ [$];
    logic [7:0]  capQ [$];

    int checks = 0;
    int failures = 0;
    int doneCount = 0;
    int dmemRdCount = 0;
    int pmemAddrMoves = 0;
    logic prevWr = 1'b0;
    logic [AW-1:0] lastPmemAddr = '0;
    logic bpMode = 1'b0;
    int lowLeft = 0;

    img_send dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_pmemSize  (pmemSize),
        .i_dmemSize  (dmemSize),
        .o_pmemAddr  (pmemAddr),
        .i_pmemRdData(pmemRdData),
        .o_dmemAddr  (dmemAddr),
        .o_dmemRd    (dmemRd),
        .i_dmemRdData(dmemRdData),
        .o_txData    (txData),
        .o_txWr      (txWr),
        .i_txReady   (txReady),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: pmem follows the address, dmem reads on strobe
    always @(posedge clk) begin
        pmemRdData <= pmem[pmemAddr[5:0]];
        if (dmemRd) dmemRdData <= dmem[dmemAddr[5:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            prevWr = 1'b0;
        end else begin
            if (txWr) begin
                checkOutput("wr_needs_ready", {31'd0, txReady}, 32'd1);
                checkOutput("wr_guard_cycle", {31'd0, prevWr}, 32'd0);
                capQ.push_back(txData);
            end
            if (done) begin
                checkOutput("done_after_last_wr", {31'd0, prevWr}, 32'd1);
                checkOutput("busy_low_at_done", {31'd0, busy}, 32'd0);
                doneCount++;
            end
            if (dmemRd) dmemRdCount++;
            if (pmemAddr != lastPmemAddr) pmemAddrMoves++;
            lastPmemAddr = pmemAddr;
            prevWr = txWr;
        end
    end

    // UART ready: held high, or randomly dropped for 0..20 cycles
    initial begin
        txReady = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!bpMode) begin
                txReady = 1'b1;
                lowLeft = 0;
            end else if (lowLeft > 0) begin
                lowLeft--;
                txReady = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                lowLeft = $urandom_range(0, 20);
                txReady = (lowLeft == 0);
                if (lowLeft > 0) lowLeft--;
            end else begin
                txReady = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Expected image straight from the framing rules
    task automatic buildExpected(input int ps, input int ds);
        expQ.delete();
        expQ.push_back(IMG_HDR0);
        expQ.push_back(IMG_HDR1);
        expQ.push_back(8'(ps / 256));
        expQ.push_back(8'(ps % 256));
        expQ.push_back(8'(ds / 256));
        expQ.push_back(8'(ds % 256));
        for (int i = 0; i < ps; i++) begin
            expQ.push_back(8'(pmem[i] / 65536));
            expQ.push_back(8'((pmem[i] / 256) % 256));
            expQ.push_back(8'(pmem[i] % 256));
        end
        for (int i = 0; i < ds; i++) begin
            expQ.push_back(8'(dmem[i] / 256));
            expQ.push_back(8'(dmem[i] % 256));
        end
    endtask

    task automatic applyStimulus(input int ps, input int ds);
        tick();
        pmemSize = ps[AW-1:0];
        dmemSize = ds[AW-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        pmemSize = AW'($urandom);
        dmemSize = AW'($urandom);
    endtask

    task automatic waitBytes(input string tag, input int n);
        int k;
        k = 0;
        while (capQ.size() < n && k < 4000) begin tick(); k++; end
        checkOutput({tag, "_bytes_reached"}, {31'd0, capQ.size() >= n}, 32'd1);
    endtask

    task automatic runImage(input string tag, input int ps, input int ds, input bit extraStart);
        int k;
        buildExpected(ps, ds);
        capQ.delete();
        doneCount = 0;
        dmemRdCount = 0;
        pmemAddrMoves = 0;
        applyStimulus(ps, ds);
        if (extraStart) begin
            waitBytes(tag, 8);
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        k = 0;
        while (doneCount == 0 && k < 4000) begin tick(); k++; end
        checkOutput({tag, "_done_seen"}, {31'd0, doneCount != 0}, 32'd1);
        repeat (4) tick();
        checkOutput({tag, "_done_once"}, doneCount, 32'd1);
        checkOutput({tag, "_byte_count"}, capQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i),
                        (i < capQ.size()) ? {24'd0, capQ[i]} : 32'hxxxxxxxx, {24'd0, expQ[i]});
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_txWr"},     {31'd0, txWr},   32'd0);
        checkOutput({tag, "_busy"},     {31'd0, busy},   32'd0);
        checkOutput({tag, "_done"},     {31'd0, done},   32'd0);
        checkOutput({tag, "_dmemRd"},   {31'd0, dmemRd}, 32'd0);
        checkOutput({tag, "_txData"},   {24'd0, txData}, 32'd0);
        checkOutput({tag, "_pmemAddr"}, 32'(pmemAddr),   32'd0);
        checkOutput({tag, "_dmemAddr"}, 32'(dmemAddr),   32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pmemSize = '0;
        dmemSize = '0;
        for (int i = 0; i < 64; i++) begin pmem[i] = '0; dmem[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        tick();
        rst = 1'b0;

        $display("[TB] basic image, ready held high");
        pmem[0] = 18'h3ABCD;
        pmem[1] = 18'h00012;
        dmem[0] = 16'h1234;
        runImage("basic", 2, 1, 1'b0);

        $display("[TB] empty memories");
        runImage("zero", 0, 0, 1'b0);
        checkOutput("zero_no_dmem_rd", dmemRdCount, 32'd0);
        checkOutput("zero_pmem_addr_still", pmemAddrMoves, 32'd0);

        $display("[TB] basic image under backpressure");
        bpMode = 1'b1;
        runImage("backpressure", 2, 1, 1'b0);
        bpMode = 1'b0;

        $display("[TB] second start during pmem phase");
        runImage("restart_ignored", 2, 1, 1'b1);

        $display("[TB] reset after eighth byte");
        capQ.delete();
        applyStimulus(2, 1);
        waitBytes("abort", 8);
        rst = 1'b1;
        @(negedge clk);
        checkIdleOutputs("abort");
        tick();
        tick();
        rst = 1'b0;
        capQ.delete();
        repeat (5) tick();
        checkOutput("abort_no_bytes_after_reset", capQ.size(), 32'd0);
        runImage("after_reset", 2, 1, 1'b0);

        $display("[TB] random images");
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 8; i++) begin
                pmem[i] = 18'($urandom);
                dmem[i] = 16'($urandom);
            end
            bpMode = 1'($urandom_range(0, 1));
            runImage($sformatf("rand%0d", r), $urandom_range(0, 6), $urandom_range(0, 6), 1'b0);
        end
        bpMode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
